// File: rtl/uram_bank_array_pkg.sv
// Shared types and helpers for the banked UltraRAM array.
// URAM_BANK_PARITY_EN adds one even-parity bit per stored word.
package uram_bank_array_pkg;

   localparam int MAX_NBPIPE = 4;
   localparam int MAX_BW     = 8;

`ifdef URAM_BANK_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   typedef struct packed {
      logic              vld;
      logic [MAX_BW-1:0] bank;
      logic              oor;
   } rd_tag_t;

   function automatic int bank_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uram_bank.sv
// One read-first true-dual-port bank with NBPIPE enabled output stages.
// Word width includes the parity bit when URAM_BANK_PARITY_EN is set.
module uram_bank #(
   parameter int AWIDTH = 12,
   parameter int W      = 32,
   parameter int NBPIPE = 1
) (
   input  logic              clk,
   input  logic              i_ena,
   input  logic              i_wea,
   input  logic [AWIDTH-1:0] i_addra,
   input  logic [W-1:0]      i_dina,
   input  logic [NBPIPE:0]   i_pena,
   output logic [W-1:0]      o_douta,
   input  logic              i_enb,
   input  logic              i_web,
   input  logic [AWIDTH-1:0] i_addrb,
   input  logic [W-1:0]      i_dinb,
   input  logic [NBPIPE:0]   i_penb,
   output logic [W-1:0]      o_doutb
);

   (* ram_style = "ultra" *)
   logic [W-1:0] r_mem [2**AWIDTH];

   logic [W-1:0] r_qa [NBPIPE+1];
   logic [W-1:0] r_qb [NBPIPE+1];

   // Port A written last so it wins if both ever write one word
   always_ff @(posedge clk) begin
      if (i_enb && i_web) r_mem[i_addrb] <= i_dinb;
      if (i_ena && i_wea) r_mem[i_addra] <= i_dina;
   end

   always_ff @(posedge clk) begin
      if (i_pena[0]) r_qa[0] <= r_mem[i_addra];
      if (i_penb[0]) r_qb[0] <= r_mem[i_addrb];
      for (int j = 1; j <= NBPIPE; j++) begin
         if (i_pena[j]) r_qa[j] <= r_qa[j-1];
         if (i_penb[j]) r_qb[j] <= r_qb[j-1];
      end
   end

   assign o_douta = r_qa[NBPIPE];
   assign o_doutb = r_qb[NBPIPE];

endmodule

// File: rtl/uram_bank_array.sv
// Dual-port memory over NBANKS banks with tagged read returns.
// Optional per-word parity via URAM_BANK_PARITY_EN.
module uram_bank_array
   import uram_bank_array_pkg::*;
#(
   parameter  int AWIDTH = 12,
   parameter  int DWIDTH = 32,
   parameter  int NBPIPE = 1,
   parameter  int NBANKS = 4,
   localparam int BW     = bank_sel_w(NBANKS),
   localparam int FAW    = AWIDTH + BW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              wea,
   input  logic [FAW-1:0]    addra,
   input  logic [DWIDTH-1:0] dina,
   output logic [DWIDTH-1:0] douta,
   output logic              rvalida,
   output logic              perra,
   input  logic              enb,
   input  logic              web,
   input  logic [FAW-1:0]    addrb,
   input  logic [DWIDTH-1:0] dinb,
   output logic [DWIDTH-1:0] doutb,
   output logic              rvalidb,
   output logic              perrb,
   output logic              collision
);

   localparam int L  = 1 + NBPIPE;
   localparam int WW = DWIDTH + PAR_W;

   if (NBPIPE < 0 || NBPIPE > MAX_NBPIPE) begin : g_chk
      $error("NBPIPE out of range");
   end

   logic [BW-1:0]     w_banka, w_bankb;
   logic [AWIDTH-1:0] w_idxa, w_idxb;
   logic              w_oora, w_oorb;
   logic              w_rda, w_rdb, w_coll;
   logic [WW-1:0]     w_wda, w_wdb;
   logic [NBANKS-1:0] w_enak, w_enbk;
   logic [NBPIPE:0]   w_pena [NBANKS];
   logic [NBPIPE:0]   w_penb [NBANKS];
   logic [WW-1:0]     w_qa [NBANKS];
   logic [WW-1:0]     w_qb [NBANKS];
   logic [WW-1:0]     w_sela, w_selb;

   rd_tag_t           r_taga [L];
   rd_tag_t           r_tagb [L];
   logic [DWIDTH-1:0] r_holda, r_holdb;
   logic              r_coll;

   assign {w_banka, w_idxa} = addra;
   assign {w_bankb, w_idxb} = addrb;
   assign w_oora = 32'(w_banka) >= NBANKS;
   assign w_oorb = 32'(w_bankb) >= NBANKS;
   assign w_rda  = ena & ~wea & ~rst;
   assign w_rdb  = enb & ~web & ~rst;
   assign w_coll = ena & wea & enb & web & ~rst & (addra == addrb);

`ifdef URAM_BANK_PARITY_EN
   assign w_wda = {^dina, dina};
   assign w_wdb = {^dinb, dinb};
`else
   assign w_wda = dina;
   assign w_wdb = dinb;
`endif

   // Port B is squashed on a collision so port A's word is kept
   always_comb begin
      w_enak = '0;
      w_enbk = '0;
      w_pena = '{default: '0};
      w_penb = '{default: '0};
      for (int k = 0; k < NBANKS; k++) begin
         w_enak[k] = ena & ~rst & (32'(w_banka) == k);
         w_enbk[k] = enb & ~rst & ~w_coll & (32'(w_bankb) == k);
         w_pena[k][0] = w_enak[k] & ~wea;
         w_penb[k][0] = w_enbk[k] & ~web;
         for (int j = 1; j <= NBPIPE; j++) begin
            w_pena[k][j] = r_taga[j-1].vld &
                           (r_taga[j-1].bank == MAX_BW'(k));
            w_penb[k][j] = r_tagb[j-1].vld &
                           (r_tagb[j-1].bank == MAX_BW'(k));
         end
      end
   end

   for (genvar k = 0; k < NBANKS; k++) begin : g_bank
      uram_bank #(
         .AWIDTH (AWIDTH),
         .W      (WW),
         .NBPIPE (NBPIPE)
      ) u_bank (
         .clk     (clk),
         .i_ena   (w_enak[k]),
         .i_wea   (wea),
         .i_addra (w_idxa),
         .i_dina  (w_wda),
         .i_pena  (w_pena[k]),
         .o_douta (w_qa[k]),
         .i_enb   (w_enbk[k]),
         .i_web   (web),
         .i_addrb (w_idxb),
         .i_dinb  (w_wdb),
         .i_penb  (w_penb[k]),
         .o_doutb (w_qb[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < L; j++) begin
            r_taga[j] <= '0;
            r_tagb[j] <= '0;
         end
         r_holda <= '0;
         r_holdb <= '0;
         r_coll  <= 1'b0;
      end else begin
         r_taga[0] <= '{vld: w_rda, bank: MAX_BW'(w_banka), oor: w_oora};
         r_tagb[0] <= '{vld: w_rdb, bank: MAX_BW'(w_bankb), oor: w_oorb};
         for (int j = 1; j < L; j++) begin
            r_taga[j] <= r_taga[j-1];
            r_tagb[j] <= r_tagb[j-1];
         end
         if (r_taga[L-1].vld) r_holda <= w_sela[DWIDTH-1:0];
         if (r_tagb[L-1].vld) r_holdb <= w_selb[DWIDTH-1:0];
         r_coll <= w_coll;
      end
   end

   always_comb begin
      w_sela = '0;
      w_selb = '0;
      for (int k = 0; k < NBANKS; k++) begin
         if (r_taga[L-1].bank == MAX_BW'(k)) w_sela = w_qa[k];
         if (r_tagb[L-1].bank == MAX_BW'(k)) w_selb = w_qb[k];
      end
      if (r_taga[L-1].oor) w_sela = '0;
      if (r_tagb[L-1].oor) w_selb = '0;
   end

   assign rvalida   = r_taga[L-1].vld;
   assign rvalidb   = r_tagb[L-1].vld;
   assign douta     = rvalida ? w_sela[DWIDTH-1:0] : r_holda;
   assign doutb     = rvalidb ? w_selb[DWIDTH-1:0] : r_holdb;
   assign collision = r_coll;

`ifdef URAM_BANK_PARITY_EN
   assign perra = rvalida & ^w_sela;
   assign perrb = rvalidb & ^w_selb;
`else
   assign perra = 1'b0;
   assign perrb = 1'b0;
`endif

endmodule
